// File: rtl/ifm_rd_arb.sv
// ----------------------------------------------------------------------------
// ifm_rd_arb
//
// Shares one IFM SRAM read port between two crdma read requesters (ID 0, 1).
// Address bursts are arbitrated round-robin, one whole burst (first..last) at
// a time. The ID of every granted burst is pushed into an in-order tag FIFO.
// Returned data bursts are steered back to the requester named by the FIFO
// head, and the tag is popped on the last beat of each data burst.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   m_addr{0,1} / _first/_last   requester address beats and burst markers
//   m_addr_valid{0,1}            requester address valid
//   m_addr_ready{0,1}            address accepted from requester
//   s_addr / _first/_last        muxed address beat to the SRAM wrapper
//   s_addr_valid / s_addr_ready  SRAM-side address handshake
//   m_data / _first/_last        SRAM read data beat and burst markers
//   m_data_valid / m_data_ready  SRAM-side data handshake
//   s_data{0,1} / _first/_last   copies of the read data for each requester
//   s_data_valid{0,1}            data valid towards requester 0/1
//   s_data_ready{0,1}            requester 0/1 accepts data
//   pend                         granted bursts whose last data beat is pending
// ----------------------------------------------------------------------------
module ifm_rd_arb #(
  parameter int AW = 14,
  parameter int DW = 8,
  parameter int DN = 8,
  parameter int TD = 4,
  parameter int TW = 3
) (
  input  logic             clk,
  input  logic             rst,

  input  logic [AW-1:0]    m_addr0,
  input  logic             m_addr_first0,
  input  logic             m_addr_last0,
  input  logic             m_addr_valid0,
  output logic             m_addr_ready0,

  input  logic [AW-1:0]    m_addr1,
  input  logic             m_addr_first1,
  input  logic             m_addr_last1,
  input  logic             m_addr_valid1,
  output logic             m_addr_ready1,

  output logic [AW-1:0]    s_addr,
  output logic             s_addr_first,
  output logic             s_addr_last,
  output logic             s_addr_valid,
  input  logic             s_addr_ready,

  input  logic [DN*DW-1:0] m_data,
  input  logic             m_data_first,
  input  logic             m_data_last,
  input  logic             m_data_valid,
  output logic             m_data_ready,

  output logic [DN*DW-1:0] s_data0,
  output logic             s_data_first0,
  output logic             s_data_last0,
  output logic             s_data_valid0,
  input  logic             s_data_ready0,

  output logic [DN*DW-1:0] s_data1,
  output logic             s_data_first1,
  output logic             s_data_last1,
  output logic             s_data_valid1,
  input  logic             s_data_ready1,

  output logic [TW-1:0]    pend
);

  localparam int PW = $clog2(TD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t        state;
  logic          rr;

  // Tag FIFO: one bit per outstanding burst, pointers wrap modulo TD.
  logic          tag_mem [TD];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [TW-1:0] count;

  logic          fifo_full;
  logic          fifo_empty;
  logic          head_tag;

  logic          cand0;
  logic          cand1;
  logic          sel_act;
  logic          sel_id;

  logic          addr_fire;
  logic          push;
  logic          data_fire;
  logic          pop;

  assign fifo_full  = (count == TW'(TD));
  assign fifo_empty = (count == '0);
  assign head_tag   = tag_mem[rd_ptr];

  assign cand0 = m_addr_valid0 & m_addr_first0;
  assign cand1 = m_addr_valid1 & m_addr_first1;

  // Grant selection. In IDLE only a first beat can win, and the full check
  // looks at the current occupancy only, so a same-cycle pop does not open
  // a slot. Inside a locked burst the owner is muxed unconditionally.
  always_comb begin
    sel_act = 1'b0;
    sel_id  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_full) begin
          if (cand0 && cand1) begin
            sel_act = 1'b1;
            sel_id  = rr;
          end else if (cand0) begin
            sel_act = 1'b1;
            sel_id  = 1'b0;
          end else if (cand1) begin
            sel_act = 1'b1;
            sel_id  = 1'b1;
          end
        end
      end
      LOCK0: begin
        sel_act = 1'b1;
        sel_id  = 1'b0;
      end
      LOCK1: begin
        sel_act = 1'b1;
        sel_id  = 1'b1;
      end
      default: begin
        sel_act = 1'b0;
        sel_id  = 1'b0;
      end
    endcase
  end

  assign s_addr       = sel_id ? m_addr1       : m_addr0;
  assign s_addr_first = sel_id ? m_addr_first1 : m_addr_first0;
  assign s_addr_last  = sel_id ? m_addr_last1  : m_addr_last0;

  // Address handshake mux; everything is held low while reset is asserted.
  always_comb begin
    s_addr_valid  = 1'b0;
    m_addr_ready0 = 1'b0;
    m_addr_ready1 = 1'b0;
    if (!rst && sel_act) begin
      if (sel_id) begin
        s_addr_valid  = m_addr_valid1;
        m_addr_ready1 = s_addr_ready;
      end else begin
        s_addr_valid  = m_addr_valid0;
        m_addr_ready0 = s_addr_ready;
      end
    end
  end

  assign s_data0       = m_data;
  assign s_data_first0 = m_data_first;
  assign s_data_last0  = m_data_last;
  assign s_data1       = m_data;
  assign s_data_first1 = m_data_first;
  assign s_data_last1  = m_data_last;

  // Data steering by the FIFO head tag. Only s_data_ready of the head owner
  // reaches m_data_ready; the address side never sees the data readies.
  always_comb begin
    m_data_ready  = 1'b0;
    s_data_valid0 = 1'b0;
    s_data_valid1 = 1'b0;
    if (!rst && !fifo_empty) begin
      if (head_tag) begin
        s_data_valid1 = m_data_valid;
        m_data_ready  = s_data_ready1;
      end else begin
        s_data_valid0 = m_data_valid;
        m_data_ready  = s_data_ready0;
      end
    end
  end

  assign addr_fire = s_addr_valid & s_addr_ready;
  assign push      = addr_fire & (state == IDLE);
  assign data_fire = m_data_valid & m_data_ready;
  assign pop       = data_fire & m_data_last;

  // Burst lock FSM, round-robin pointer and FIFO pointers/occupancy.
  // The preferred requester flips to the other one after each completed burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr     <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (addr_fire) begin
        case (state)
          IDLE: begin
            if (s_addr_last) begin
              rr <= ~sel_id;
            end else begin
              state <= sel_id ? LOCK1 : LOCK0;
            end
          end
          LOCK0, LOCK1: begin
            if (s_addr_last) begin
              state <= IDLE;
              rr    <= ~sel_id;
            end
          end
          default: state <= IDLE;
        endcase
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + TW'(push) - TW'(pop);
    end
  end

  // Tag storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= sel_id;
    end
  end

  assign pend = count;

endmodule

// File: tb/tb_ifm_rd_arb.sv
// ----------------------------------------------------------------------------
// tb_ifm_rd_arb
//
// Randomised bench for ifm_rd_arb. Two requester agents issue address bursts,
// an SRAM agent returns one data burst per completed address burst, and two
// data sinks apply random backpressure. A transaction-level reference model
// (queue of outstanding burst owners, current lock owner, preferred
// requester) predicts every handshake output each cycle.
// ----------------------------------------------------------------------------
module tb_ifm_rd_arb;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int DN = 8;
  localparam int TD = 4;
  localparam int TW = 3;
  localparam int BW = DN * DW;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] m_addr0, m_addr1, s_addr;
  logic          m_addr_first0, m_addr_last0, m_addr_valid0, m_addr_ready0;
  logic          m_addr_first1, m_addr_last1, m_addr_valid1, m_addr_ready1;
  logic          s_addr_first, s_addr_last, s_addr_valid, s_addr_ready;
  logic [BW-1:0] m_data, s_data0, s_data1;
  logic          m_data_first, m_data_last, m_data_valid, m_data_ready;
  logic          s_data_first0, s_data_last0, s_data_valid0, s_data_ready0;
  logic          s_data_first1, s_data_last1, s_data_valid1, s_data_ready1;
  logic [TW-1:0] pend;

  ifm_rd_arb #(.AW(AW), .DW(DW), .DN(DN), .TD(TD), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .m_addr0(m_addr0), .m_addr_first0(m_addr_first0), .m_addr_last0(m_addr_last0),
    .m_addr_valid0(m_addr_valid0), .m_addr_ready0(m_addr_ready0),
    .m_addr1(m_addr1), .m_addr_first1(m_addr_first1), .m_addr_last1(m_addr_last1),
    .m_addr_valid1(m_addr_valid1), .m_addr_ready1(m_addr_ready1),
    .s_addr(s_addr), .s_addr_first(s_addr_first), .s_addr_last(s_addr_last),
    .s_addr_valid(s_addr_valid), .s_addr_ready(s_addr_ready),
    .m_data(m_data), .m_data_first(m_data_first), .m_data_last(m_data_last),
    .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
    .s_data0(s_data0), .s_data_first0(s_data_first0), .s_data_last0(s_data_last0),
    .s_data_valid0(s_data_valid0), .s_data_ready0(s_data_ready0),
    .s_data1(s_data1), .s_data_first1(s_data_first1), .s_data_last1(s_data_last1),
    .s_data_valid1(s_data_valid1), .s_data_ready1(s_data_ready1),
    .pend(pend)
  );

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;

  // Reference model: owners of outstanding bursts in grant order, the
  // requester currently holding a burst lock (-1 = none), preferred requester.
  int tagq[$];
  int owner = -1;
  int pref  = 0;

  // Requester agents.
  bit            rq_active [2];
  bit            rq_valid  [2];
  int            rq_len    [2];
  int            rq_idx    [2];
  logic [AW-1:0] rq_base   [2];
  bit            acc       [2];

  // SRAM agent: lengths of data bursts still to be returned, in order.
  int            dq_len[$];
  int            d_idx = 0;
  bit            d_valid = 1'b0;
  logic [BW-1:0] d_word = '0;
  bit            dacc = 1'b0;

  // Phase knobs.
  int p_req = 60;
  int p_rdy = 70;
  bit single_beat = 1'b0;
  bit hold_data   = 1'b0;
  bit hold_rdy1   = 1'b0;
  bit rst_pulses  = 1'b0;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advances all agents by one cycle and drives the DUT inputs.
  task automatic applyStimulus();
    bit do_rst;
    do_rst = (cyc < 2) || (rst_pulses && ($urandom_range(59) == 0));
    rst = do_rst;
    if (do_rst) begin
      for (int r = 0; r < 2; r++) begin
        rq_active[r] = 1'b0;
        rq_valid[r]  = 1'b0;
        acc[r]       = 1'b0;
      end
      dq_len.delete();
      d_idx   = 0;
      d_valid = 1'b0;
      dacc    = 1'b0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (acc[r]) begin
          rq_valid[r] = 1'b0;
          rq_idx[r]++;
          if (rq_idx[r] == rq_len[r]) rq_active[r] = 1'b0;
        end
        if (!rq_active[r] && ($urandom_range(99) < p_req)) begin
          rq_active[r] = 1'b1;
          rq_idx[r]    = 0;
          rq_len[r]    = single_beat ? 1 : int'($urandom_range(4, 1));
          rq_base[r]   = AW'($urandom);
        end
        if (rq_active[r] && !rq_valid[r] && ($urandom_range(99) < p_req)) rq_valid[r] = 1'b1;
      end
      if (dacc) begin
        d_valid = 1'b0;
        d_idx++;
        if (d_idx == dq_len[0]) begin
          void'(dq_len.pop_front());
          d_idx = 0;
        end
      end
      if ((dq_len.size() > 0) && !d_valid && !hold_data && ($urandom_range(99) < p_req)) begin
        d_valid = 1'b1;
        d_word  = {$urandom, $urandom};
      end
    end
    s_addr_ready  = ($urandom_range(99) < p_rdy);
    s_data_ready0 = ($urandom_range(99) < p_rdy);
    s_data_ready1 = !hold_rdy1 && ($urandom_range(99) < p_rdy);

    m_addr0       = rq_base[0] + AW'(rq_idx[0]);
    m_addr_first0 = (rq_idx[0] == 0);
    m_addr_last0  = (rq_idx[0] == rq_len[0] - 1);
    m_addr_valid0 = rq_valid[0];
    m_addr1       = rq_base[1] + AW'(rq_idx[1]);
    m_addr_first1 = (rq_idx[1] == 0);
    m_addr_last1  = (rq_idx[1] == rq_len[1] - 1);
    m_addr_valid1 = rq_valid[1];

    m_data       = d_word;
    m_data_valid = d_valid;
    m_data_first = (d_idx == 0);
    m_data_last  = (dq_len.size() > 0) && (d_idx == dq_len[0] - 1);
  endtask

  // Predicts this cycle's outputs from the model, compares, then advances the
  // model to the state after the coming clock edge.
  task automatic checkCycle();
    int            sel;
    int            h;
    bit            ev, er0, er1, edr, edv0, edv1, ef, el;
    logic [AW-1:0] ea;
    sel = -1; h = -1;
    ev = 1'b0; er0 = 1'b0; er1 = 1'b0; edr = 1'b0; edv0 = 1'b0; edv1 = 1'b0;
    ef = 1'b0; el = 1'b0; ea = '0;

    checkOutput("pend", 64'(pend), 64'(tagq.size()));

    if (!rst) begin
      if (owner >= 0) begin
        sel = owner;
      end else if (tagq.size() < TD) begin
        if (m_addr_valid0 && m_addr_first0 && m_addr_valid1 && m_addr_first1) sel = pref;
        else if (m_addr_valid0 && m_addr_first0) sel = 0;
        else if (m_addr_valid1 && m_addr_first1) sel = 1;
      end
      if (sel == 0) begin
        ev = m_addr_valid0; er0 = s_addr_ready;
        ea = m_addr0; ef = m_addr_first0; el = m_addr_last0;
      end else if (sel == 1) begin
        ev = m_addr_valid1; er1 = s_addr_ready;
        ea = m_addr1; ef = m_addr_first1; el = m_addr_last1;
      end
      if (tagq.size() > 0) begin
        h = tagq[0];
        if (h == 1) begin
          edv1 = m_data_valid; edr = s_data_ready1;
        end else begin
          edv0 = m_data_valid; edr = s_data_ready0;
        end
      end
    end

    checkOutput("s_addr_valid", 64'(s_addr_valid), 64'(ev));
    checkOutput("m_addr_ready0", 64'(m_addr_ready0), 64'(er0));
    checkOutput("m_addr_ready1", 64'(m_addr_ready1), 64'(er1));
    checkOutput("m_data_ready", 64'(m_data_ready), 64'(edr));
    checkOutput("s_data_valid0", 64'(s_data_valid0), 64'(edv0));
    checkOutput("s_data_valid1", 64'(s_data_valid1), 64'(edv1));
    if (ev) begin
      checkOutput("s_addr", 64'(s_addr), 64'(ea));
      checkOutput("s_addr_first", 64'(s_addr_first), 64'(ef));
      checkOutput("s_addr_last", 64'(s_addr_last), 64'(el));
    end
    if (edv0 && s_data_ready0) begin
      checkOutput("s_data0", s_data0, d_word);
      checkOutput("s_data_last0", 64'(s_data_last0), 64'(m_data_last));
    end
    if (edv1 && s_data_ready1) begin
      checkOutput("s_data1", s_data1, d_word);
      checkOutput("s_data_last1", 64'(s_data_last1), 64'(m_data_last));
    end

    acc[0] = ev && (sel == 0) && s_addr_ready;
    acc[1] = ev && (sel == 1) && s_addr_ready;
    dacc   = edr && m_data_valid;

    if (rst) begin
      tagq.delete();
      owner = -1;
      pref  = 0;
    end else begin
      if (dacc && m_data_last) void'(tagq.pop_front());
      if (ev && s_addr_ready) begin
        if (owner < 0) tagq.push_back(sel);
        if (el) begin
          owner = -1;
          pref  = 1 - sel;
          dq_len.push_back(int'($urandom_range(3, 1)));
        end else begin
          owner = sel;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    m_addr0 = '0; m_addr_first0 = 1'b0; m_addr_last0 = 1'b0; m_addr_valid0 = 1'b0;
    m_addr1 = '0; m_addr_first1 = 1'b0; m_addr_last1 = 1'b0; m_addr_valid1 = 1'b0;
    s_addr_ready = 1'b0;
    m_data = '0; m_data_first = 1'b0; m_data_last = 1'b0; m_data_valid = 1'b0;
    s_data_ready0 = 1'b0; s_data_ready1 = 1'b0;
    for (int r = 0; r < 2; r++) begin
      rq_active[r] = 1'b0; rq_valid[r] = 1'b0; rq_len[r] = 1;
      rq_idx[r] = 0; rq_base[r] = '0; acc[r] = 1'b0;
    end

    for (int c = 0; c < NCYC; c++) begin
      cyc = c;
      single_beat = (c >= 800) && (c < 900);
      hold_data   = (c >= 900) && (c < 1000);
      hold_rdy1   = (c >= 1000) && (c < 1100);
      rst_pulses  = (c >= 1100);
      p_req       = single_beat ? 100 : (hold_data ? 80 : 60);
      p_rdy       = single_beat ? 100 : 70;
      @(posedge clk);
      #1;
      applyStimulus();
      #5;
      checkCycle();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
